// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state types
// used by the on-chip data memory responder.
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_RESP
    } axil_wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } axil_rd_state_t;

endpackage

// File: rtl/axil_slave_ram.sv
// Word memory with per-byte write enables and a registered
// read port that returns pre-write data on same-word collision.
module axil_slave_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [STRB_WIDTH-1:0] we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite responder fronting a byte-writable word memory;
// independent write and read FSMs, readies decoded from state.
module axil_slave_mem
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  aclk,
    input  logic                  anreset,
    input  logic                  aenable,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [2:0]            i_awprot,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [2:0]            i_arprot,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rvalid,
    input  logic                  i_rready
);

    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * STRB_WIDTH);

    axil_wr_state_t w_state, w_next;
    axil_rd_state_t r_state, r_next;

    logic                  en;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [ADDR_WIDTH:0]   aw_off, ar_off;
    logic                  aw_in, ar_in;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  aw_in_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  commit, cm_in;
    logic [IDX_W-1:0]      cm_idx;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_WIDTH-1:0] cm_strb;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_bits;

    // Top bit of the offset is the borrow, i.e. addr < BASE_ADDR
    assign aw_off = {1'b0, i_awaddr} - {1'b0, BASE_ADDR};
    assign ar_off = {1'b0, i_araddr} - {1'b0, BASE_ADDR};
    assign aw_in  = !aw_off[ADDR_WIDTH] && (aw_off[ADDR_WIDTH-1:0] < SPAN);
    assign ar_in  = !ar_off[ADDR_WIDTH] && (ar_off[ADDR_WIDTH-1:0] < SPAN);
    assign aw_idx = aw_off[LSB +: IDX_W];
    assign ar_idx = ar_off[LSB +: IDX_W];

    assign unused_bits = ^{i_awprot, i_arprot, aw_off, ar_off};

    assign en        = aenable & anreset;
    assign o_awready = en && (w_state == W_IDLE || w_state == W_WAIT_ADDR);
    assign o_wready  = en && (w_state == W_IDLE || w_state == W_WAIT_DATA);
    assign o_arready = en && (r_state == R_IDLE);
    assign o_bvalid  = (w_state == W_RESP);
    assign o_rvalid  = (r_state == R_RESP);
    assign o_rdata   = rd_ok ? ram_rdata : '0;

    assign aw_hs = i_awvalid & o_awready;
    assign w_hs  = i_wvalid  & o_wready;
    assign ar_hs = i_arvalid & o_arready;
    assign b_hs  = o_bvalid  & i_bready & en;
    assign r_hs  = o_rvalid  & i_rready & en;

    always_comb begin
        w_next  = w_state;
        commit  = 1'b0;
        cm_in   = aw_in;
        cm_idx  = aw_idx;
        cm_data = i_wdata;
        cm_strb = i_wstrb;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end else if (aw_hs) begin
                    w_next = W_WAIT_DATA;
                end else if (w_hs) begin
                    w_next = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                cm_in  = aw_in_q;
                cm_idx = aw_idx_q;
                if (w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_WAIT_ADDR: begin
                cm_data = w_data_q;
                cm_strb = w_strb_q;
                if (aw_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_RESP: begin
                if (b_hs) w_next = W_IDLE;
            end
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_next = R_RESP;
            R_RESP: if (r_hs)  r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!anreset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            o_bresp <= AXIL_RESP_OKAY;
            o_rresp <= AXIL_RESP_OKAY;
            rd_ok   <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            if (commit) o_bresp <= cm_in ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
            if (ar_hs) begin
                o_rresp <= ar_in ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
                rd_ok   <= ar_in;
            end
        end
    end

    // Holding registers are only meaningful in the wait states
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            aw_in_q  <= aw_in;
            aw_idx_q <= aw_idx;
        end
        if (w_hs) begin
            w_data_q <= i_wdata;
            w_strb_q <= i_wstrb;
        end
    end

    axil_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk   (aclk),
        .we    ((commit && cm_in) ? cm_strb : '0),
        .waddr (cm_idx),
        .wdata (cm_data),
        .re    (ar_hs && ar_in),
        .raddr (ar_idx),
        .rdata (ram_rdata)
    );

endmodule
